// File: rtl/rpn_pkg.sv
`default_nettype none
// ============================================================================
//  Module : rpn_pkg
//  Purpose: Shared definitions for the RPN calculator front end and ALU:
//           sequencer state encoding, default sizes, operation codes and
//           the reserved (rejected) operation code.
//  Ports  : none (package)
//  Rev    : 1.0 - initial release
// ============================================================================
package rpn_pkg;

  // Default datapath sizes
  localparam int LARGURA_PADRAO      = 8;
  localparam int PROFUNDIDADE_PADRAO = 4;

  // Operation codes, shared with the ALU decoder
  localparam logic [2:0] OP_SOMA  = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_NOT   = 3'b110;
  localparam logic [2:0] OP_INVALIDO_PADRAO = 3'b111;

  // Sequencer states
  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    PUSH   = 3'd1,
    OPER   = 3'd2,
    EXEC   = 3'd3,
    CHECA  = 3'd4,
    ERRO   = 3'd5
  } estado_t;

endpackage : rpn_pkg
`default_nettype wire

// File: rtl/detector_borda.sv
`default_nettype none
// ============================================================================
//  Module : detector_borda
//  Purpose: Registers a level key once and flags its rising edge
//           (key high while the registered copy is still low).
//  Ports  : clk, rst (async, active-high), tecla (level in),
//           borda (rising-edge flag, combinational from tecla and history)
//  Rev    : 1.0 - initial release
// ============================================================================
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic tecla,
  output logic borda
);

  logic anterior;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) anterior <= 1'b0;
    else     anterior <= tecla;
  end

  assign borda = tecla & ~anterior;

endmodule : detector_borda
`default_nettype wire

// File: rtl/controlador_rpn.sv
`default_nettype none
// ============================================================================
//  Module : controlador_rpn
//  Purpose: Key-driven sequencer for the RPN stack. Latches operand and
//           operation code, turns key edges into one-cycle push / operation /
//           execute pulses, tracks stack depth against overflow/underflow and
//           captures the ALU error flag after each execute.
//  Ports  : clk, rst (async, active-high)
//           valor, op_sel            - operand / operation switches
//           tecla_numero/operacao/executar - level keys
//           limpar                   - clears the error state
//           erro_ula                 - ALU error flag
//           entrada, operacao        - registered operand / op code
//           entrada_numero, entrada_operacao, executar - one-cycle pulses
//           profundidade, op_valido, ocupado, erro     - status
//  Rev    : 1.0 - initial release
// ============================================================================
module controlador_rpn
  import rpn_pkg::*;
#(
  parameter int         LARGURA      = LARGURA_PADRAO,
  parameter int         PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter logic [2:0] OP_INVALIDO  = OP_INVALIDO_PADRAO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] valor,
  input  logic [2:0]         op_sel,
  input  logic               tecla_numero,
  input  logic               tecla_operacao,
  input  logic               tecla_executar,
  input  logic               limpar,
  input  logic               erro_ula,
  output logic [LARGURA-1:0] entrada,
  output logic [2:0]         operacao,
  output logic               entrada_numero,
  output logic               entrada_operacao,
  output logic               executar,
  output logic [2:0]         profundidade,
  output logic               op_valido,
  output logic               ocupado,
  output logic               erro
);

  localparam logic [2:0] PROF_MAX = 3'(PROFUNDIDADE);

  estado_t estado;
  logic    borda_num, borda_op, borda_exe;

  detector_borda u_borda_num (.clk(clk), .rst(rst), .tecla(tecla_numero),   .borda(borda_num));
  detector_borda u_borda_op  (.clk(clk), .rst(rst), .tecla(tecla_operacao), .borda(borda_op));
  detector_borda u_borda_exe (.clk(clk), .rst(rst), .tecla(tecla_executar), .borda(borda_exe));

  // The pulse and the depth update are issued from inside PUSH/OPER/EXEC, so
  // they appear one cycle after the state is entered, i.e. one full cycle
  // after the key edge was sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado           <= OCIOSO;
      entrada          <= '0;
      operacao         <= '0;
      entrada_numero   <= 1'b0;
      entrada_operacao <= 1'b0;
      executar         <= 1'b0;
      profundidade     <= '0;
      op_valido        <= 1'b0;
      ocupado          <= 1'b0;
      erro             <= 1'b0;
    end else begin
      entrada_numero   <= 1'b0;
      entrada_operacao <= 1'b0;
      executar         <= 1'b0;
      case (estado)
        OCIOSO: begin
          // Priority executar > operacao > numero; losers are dropped.
          if (borda_exe) begin
            ocupado <= 1'b1;
            if (profundidade >= 3'd2 && op_valido) begin
              estado <= EXEC;
            end else begin
              estado <= ERRO;
              erro   <= 1'b1;
            end
          end else if (borda_op) begin
            ocupado <= 1'b1;
            if (op_sel != OP_INVALIDO) begin
              operacao <= op_sel;
              estado   <= OPER;
            end else begin
              estado <= ERRO;
              erro   <= 1'b1;
            end
          end else if (borda_num) begin
            ocupado <= 1'b1;
            if (profundidade < PROF_MAX) begin
              entrada <= valor;
              estado  <= PUSH;
            end else begin
              estado <= ERRO;
              erro   <= 1'b1;
            end
          end
        end
        PUSH: begin
          entrada_numero <= 1'b1;
          profundidade   <= profundidade + 3'd1;
          estado         <= OCIOSO;
          ocupado        <= 1'b0;
        end
        OPER: begin
          entrada_operacao <= 1'b1;
          op_valido        <= 1'b1;
          estado           <= OCIOSO;
          ocupado          <= 1'b0;
        end
        EXEC: begin
          // Two pops and one push: net depth change is -1.
          executar     <= 1'b1;
          profundidade <= profundidade - 3'd1;
          op_valido    <= 1'b0;
          estado       <= CHECA;
        end
        CHECA: begin
          if (erro_ula) begin
            estado <= ERRO;
            erro   <= 1'b1;
          end else begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
        end
        ERRO: begin
          if (limpar) begin
            erro    <= 1'b0;
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
        end
        default: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule : controlador_rpn
`default_nettype wire

// File: doc/controlador_rpn.md
Name: controlador_rpn

Overview:
- Front-end sequencer that drives the RPN stack's command interface from user keys.
- Latches the operand value and the operation code.
- Converts key presses into single-cycle push, operation and execute pulses.
- Tracks stack depth to block overflow and underflow, and captures the ALU error flag after each execute.
- Sits between the board keys/switches and the stack/ALU datapath; it initiates every stack transaction.

Parameters:
- LARGURA, 8, operand width in bits.
- PROFUNDIDADE, 4, stack capacity; the depth counter saturates here.
- OP_INVALIDO, 3'b111, reserved operation code that is rejected.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- valor  input  LARGURA  operand switches.
- op_sel  input  3  operation switches.
- tecla_numero  input  1  level key: push operand.
- tecla_operacao  input  1  level key: select operation.
- tecla_executar  input  1  level key: execute.
- limpar  input  1  synchronous clear of the error state.
- erro_ula  input  1  ALU error flag from the stack block.
- entrada  output  LARGURA  registered operand to the stack.
- operacao  output  3  registered operation code to the stack/ALU.
- entrada_numero  output  1  one-cycle push pulse.
- entrada_operacao  output  1  one-cycle operation-select pulse.
- executar  output  1  one-cycle execute pulse.
- profundidade  output  3  current tracked depth, 0..PROFUNDIDADE.
- op_valido  output  1  an operation is selected and not yet consumed.
- ocupado  output  1  FSM not in OCIOSO.
- erro  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, the FSM goes to OCIOSO, and the key history registers clear to 0.
- Each key is registered once. A rising edge means key=1 while its registered copy=0.
- Edges are acted on only in OCIOSO. Edges arriving in any other state are dropped; there is no queueing.
- Simultaneous edges: priority is executar > operacao > numero. Lower-priority edges in the same cycle are dropped.
- FSM states: OCIOSO, PUSH, OPER, EXEC, CHECA, ERRO.
- OCIOSO + numero edge:
  - If profundidade < PROFUNDIDADE: latch valor into entrada and go to PUSH.
  - Else: go to ERRO (overflow); entrada is unchanged.
- OCIOSO + operacao edge:
  - If op_sel != OP_INVALIDO: latch it into operacao and go to OPER.
  - Else: go to ERRO.
- OCIOSO + executar edge:
  - If profundidade >= 2 and op_valido=1: go to EXEC.
  - Else: go to ERRO (underflow or no operation selected).
- PUSH: entrada_numero=1 for exactly this cycle; profundidade+1; next state OCIOSO.
- OPER: entrada_operacao=1 for this cycle; op_valido set to 1; next state OCIOSO.
- EXEC: executar=1 for this cycle; profundidade-1 (two pops, one push); op_valido cleared; next state CHECA.
- CHECA: sample erro_ula.
  - If 1: go to ERRO.
  - Else: go to OCIOSO.
- ERRO:
  - erro=1 and ocupado=1; all pulses 0.
  - Stays in ERRO until limpar=1, which clears erro and returns to OCIOSO.
  - profundidade, entrada, operacao and op_valido are preserved.
- limpar in any other state has no effect.
- Pulse latency: a key edge sampled at clock edge k produces its pulse during cycle k+1 (the interval between edges k+1 and k+2). Each pulse lasts exactly 1 cycle.
- A key held high produces one action only; it must return to 0 before it is recognised again.
- entrada and operacao are stable for the whole pulse cycle and hold afterwards.
- profundidade never exceeds PROFUNDIDADE and never goes below 0; guarded transitions make wrap-around impossible.
- Reset asserted mid-pulse (in PUSH or EXEC) truncates the pulse immediately. The stack shares rst, so depth 0 stays consistent.

Decomposition:
- Shared package rpn_pkg holds:
  - FSM state encoding (3-bit, 6 states);
  - OP_INVALIDO;
  - default LARGURA and PROFUNDIDADE;
  - the operation code constants, shared with the ALU decoder.
- One natural sub-module: detector_borda (register plus rising-edge output, with asynchronous reset), instantiated three times.

Test Plan:
- Push sequence: valor=8'h05 then 8'h03 on tecla_numero presses → two entrada_numero pulses, entrada=05 then 03, profundidade=2, erro=0.
- Execute sequence: op_sel=3'b000 on tecla_operacao, then tecla_executar → entrada_operacao pulse, then executar pulse one cycle after its edge, profundidade=1, op_valido=0.
- Underflow: after reset, press tecla_executar → no executar pulse, erro=1; limpar=1 → erro=0, FSM in OCIOSO, profundidade=0.
- Overflow: 4 pushes, then a 5th → profundidade stays 4, no 5th pulse, erro=1.
- Simultaneous tecla_numero and tecla_operacao edges → only entrada_operacao pulses. A key held high for 10 cycles → exactly one pulse.
- ALU error: at depth 2 with a valid op, erro_ula=1 during CHECA → erro=1; reset asserted mid-EXEC → all outputs 0 asynchronously.
